aes_iter_engine: RTL and testbench

//  Iterative AES-128 encrypt/decrypt engine with valid/ready handshakes on both sides.

---
 rtl/aes_iter_engine.sv | 322 ++++++++++++++++++++++++++++++++
 tb/tb_aes_iter_engine.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_iter_engine.sv
// aes_iter_engine
//  Iterative AES-128 encrypt/decrypt engine with valid/ready handshakes on
//  both sides. RPC rounds are evaluated per clock. A single-entry cache keeps
//  the round-10 key of the most recent expansion or encryption, so that a
//  decrypt under that key can start its inverse rounds at once.
//
//  Each unrolled stage is one key-schedule step followed by one encrypt or
//  decrypt round (functions key_step, enc_round, dec_round below).
//
// Parameters
//  RPC        rounds per cycle (1, 2, 5 or 10)
//  KEY_CACHE  1 = last-round-key cache enabled
// Ports
//  CLK        clock, rising edge
//  nRST       asynchronous active-low reset
//  IN_VALID   request valid
//  IN_READY   engine accepts a request this cycle
//  ENCDEC     0 = encrypt, 1 = decrypt (sampled at accept)
//  KEY        128-bit cipher key (sampled at accept)
//  TEXTIN     128-bit plaintext/ciphertext (sampled at accept)
//  OUT_VALID  result valid, held until OUT_READY
//  OUT_READY  consumer takes the result
//  TEXTOUT    128-bit result
//  CACHE_HIT  with OUT_VALID: this decrypt skipped key expansion
//  BUSY       engine not idle
module aes_iter_engine #(
  parameter int RPC       = 1,
  parameter bit KEY_CACHE = 1'b1
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         IN_VALID,
  output logic         IN_READY,
  input  logic         ENCDEC,
  input  logic [127:0] KEY,
  input  logic [127:0] TEXTIN,
  output logic         OUT_VALID,
  input  logic         OUT_READY,
  output logic [127:0] TEXTOUT,
  output logic         CACHE_HIT,
  output logic         BUSY
);

  localparam logic [3:0] STEP      = 4'(RPC);
  // Counter value at the start of the cycle whose last stage is round 10.
  localparam logic [3:0] LAST_BASE = 4'(11 - RPC);

  typedef enum logic [1:0] {IDLE, KEYEXP, ROUND, OUTPUT} state_t;

  // ---------------- GF(2^8) and AES primitives ----------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = x;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) r = gmul(r, p);
      p = gmul(p, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] y;
    y = ginv(x);
    return y ^ rotl8(y, 1) ^ rotl8(y, 2) ^ rotl8(y, 3) ^ rotl8(y, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return ginv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
  endfunction

  // Byte i of a block sits at [127-8i -: 8]; byte 4c+r is row r, column c.
  function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++)
      o[127-8*i -: 8] = inv ? inv_sbox(s[127-8*i -: 8]) : sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    int src;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        src = inv ? (c - r + 4) % 4 : (c + r) % 4;
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*src+r) -: 8];
      end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      if (!inv) begin
        o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end else begin
        o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
        o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
        o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
        o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
      end
    end
    return o;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  // Forward step: key(idx-1) -> key(idx). Inverse step for decrypt round idx:
  // key(11-idx) -> key(10-idx), which uses the Rcon of round 11-idx.
  function automatic logic [127:0] key_step(input logic [127:0] k, input logic [3:0] idx,
                                            input logic inv);
    logic [31:0] w0, w1, w2, w3, n0, n1, n2, n3;
    logic [7:0]  rc;
    {w0, w1, w2, w3} = k;
    rc = rcon(inv ? 4'(4'd11 - idx) : idx);
    if (!inv) begin
      n0 = w0 ^ sub_rot_word(w3) ^ {rc, 24'h0};
      n1 = w1 ^ n0;
      n2 = w2 ^ n1;
      n3 = w3 ^ n2;
    end else begin
      n3 = w3 ^ w2;
      n2 = w2 ^ w1;
      n1 = w1 ^ w0;
      n0 = w0 ^ sub_rot_word(n3) ^ {rc, 24'h0};
    end
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [127:0] enc_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic [3:0] idx);
    logic [127:0] t;
    t = shift_rows(sub_bytes(s, 1'b0), 1'b0);
    if (idx != 4'd10) t = mix_columns(t, 1'b0);
    return t ^ k;
  endfunction

  // Decrypt round idx (1..10) consumes key(10-idx); the final one skips InvMixColumns.
  function automatic logic [127:0] dec_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic [3:0] idx);
    logic [127:0] t;
    t = sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ k;
    if (idx != 4'd10) t = mix_columns(t, 1'b1);
    return t;
  endfunction

  // ---------------- state and datapath ----------------
  state_t       state, next_state;
  logic [127:0] text, key, key_lat;
  logic [3:0]   krnd, rnd;
  logic         dec_mode, hit_lat;
  logic         cache_valid;
  logic [127:0] cache_key, cache_lastkey;

  logic         accept, hit, last_step, key_inv;
  logic [3:0]   base_cnt;
  logic [127:0] ks_out, txt_out;

  assign IN_READY  = (state == IDLE) | ((state == OUTPUT) & OUT_READY);
  assign accept    = IN_VALID & IN_READY;
  assign hit       = KEY_CACHE & cache_valid & (KEY == cache_key);
  assign BUSY      = (state != IDLE);
  assign base_cnt  = (state == KEYEXP) ? krnd : rnd;
  assign last_step = (base_cnt == LAST_BASE);
  assign key_inv   = (state == ROUND) & dec_mode;

  // RPC chained stages; the key register doubles as tmpkey during KEYEXP.
  always_comb begin : stage_chain
    logic [127:0] k_c;
    logic [127:0] t_c;
    logic [3:0]   idx;
    k_c = key;
    t_c = text;
    idx = base_cnt;
    for (int j = 0; j < RPC; j++) begin
      idx = base_cnt + 4'(j);
      k_c = key_step(k_c, idx, key_inv);
      t_c = dec_mode ? dec_round(t_c, k_c, idx) : enc_round(t_c, k_c, idx);
    end
    ks_out  = k_c;
    txt_out = t_c;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = (ENCDEC & ~hit) ? KEYEXP : ROUND;
      KEYEXP:  if (last_step) next_state = ROUND;
      ROUND:   if (last_step) next_state = OUTPUT;
      OUTPUT: begin
        if (accept)         next_state = (ENCDEC & ~hit) ? KEYEXP : ROUND;
        else if (OUT_READY) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      text          <= '0;
      key           <= '0;
      key_lat       <= '0;
      krnd          <= '0;
      rnd           <= '0;
      dec_mode      <= 1'b0;
      hit_lat       <= 1'b0;
      cache_valid   <= 1'b0;
      cache_key     <= '0;
      cache_lastkey <= '0;
      OUT_VALID     <= 1'b0;
      TEXTOUT       <= '0;
      CACHE_HIT     <= 1'b0;
    end else begin
      if ((state == OUTPUT) && OUT_READY) begin
        OUT_VALID <= 1'b0;
        CACHE_HIT <= 1'b0;
      end
      if (accept) begin
        dec_mode <= ENCDEC;
        key_lat  <= KEY;
        hit_lat  <= ENCDEC & hit;
        krnd     <= 4'd1;
        rnd      <= 4'd1;
        if (!ENCDEC) begin
          text <= TEXTIN ^ KEY;
          key  <= KEY;
        end else if (hit) begin
          text <= TEXTIN ^ cache_lastkey;
          key  <= cache_lastkey;
        end else begin
          text <= TEXTIN;
          key  <= KEY;
        end
      end else if (state == KEYEXP) begin
        key <= ks_out;
        if (last_step) begin
          text <= text ^ ks_out;
          rnd  <= 4'd1;
          if (KEY_CACHE) begin
            cache_key     <= key_lat;
            cache_lastkey <= ks_out;
            cache_valid   <= 1'b1;
          end
        end else begin
          krnd <= krnd + STEP;
        end
      end else if (state == ROUND) begin
        text <= txt_out;
        key  <= ks_out;
        if (last_step) begin
          TEXTOUT   <= txt_out;
          OUT_VALID <= 1'b1;
          CACHE_HIT <= hit_lat;
          if (KEY_CACHE && !dec_mode) begin
            cache_key     <= key_lat;
            cache_lastkey <= ks_out;
            cache_valid   <= 1'b1;
          end
        end else begin
          rnd <= rnd + STEP;
        end
      end
    end
  end

endmodule

// File: tb/tb_aes_iter_engine.sv
// tb_aes_iter_engine
//  Self-checking bench for aes_iter_engine. The reference is a table-driven
//  AES-128 working on a 4x4 byte matrix, with its own key expansion and a
//  one-entry cache model.
module tb_aes_iter_engine #(
  parameter int RPC = 1
);

  localparam int NCYC = 10 / RPC;

  logic         CLK, nRST, IN_VALID, IN_READY, ENCDEC;
  logic [127:0] KEY, TEXTIN, TEXTOUT;
  logic         OUT_VALID, OUT_READY, CACHE_HIT, BUSY;

  int checks = 0;
  int errors = 0;

  bit           m_cache_valid = 1'b0;
  logic [127:0] m_cache_key   = '0;

  logic [7:0] sb  [256];
  logic [7:0] isb [256];

  aes_iter_engine #(.RPC(RPC), .KEY_CACHE(1'b1)) dut (
    .CLK(CLK), .nRST(nRST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .ENCDEC(ENCDEC), .KEY(KEY), .TEXTIN(TEXTIN), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .TEXTOUT(TEXTOUT), .CACHE_HIT(CACHE_HIT), .BUSY(BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] m_rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] m_xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = m_xt(x);
    end
    return p;
  endfunction

  // S-box generated by walking generator 3 and its inverse in lockstep.
  task automatic build_tables();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ ((p & 8'h80) != 0 ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if ((q & 8'h80) != 0) q = q ^ 8'h09;
      x = q ^ m_rotl(q, 1) ^ m_rotl(q, 2) ^ m_rotl(q, 3) ^ m_rotl(q, 4);
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
    for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);
  endtask

  function automatic logic [127:0] mdl_rk(input logic [127:0] key, input int r);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc, 24'h0};
        rc = m_xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] mdl_cipher(input bit dec, input logic [127:0] key,
                                              input logic [127:0] blk);
    logic [7:0]   m [4][4];
    logic [7:0]   n [4][4];
    logic [7:0]   a [4];
    logic [127:0] rk;
    logic [127:0] res;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) m[r][c] = blk[127-8*(4*c+r) -: 8];
    for (int s = 0; s <= 10; s++) begin
      if (s > 0) begin
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++)
            n[r][c] = dec ? isb[m[r][(c-r+4)%4]] : sb[m[r][(c+r)%4]];
        m = n;
        if (!dec && s < 10)
          for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) a[r] = m[r][c];
            for (int r = 0; r < 4; r++)
              m[r][c] = m_mul(a[r], 8'd2) ^ m_mul(a[(r+1)%4], 8'd3) ^ a[(r+2)%4] ^ a[(r+3)%4];
          end
      end
      rk = mdl_rk(key, dec ? 10 - s : s);
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) m[r][c] ^= rk[127-8*(4*c+r) -: 8];
      if (dec && s > 0 && s < 10)
        for (int c = 0; c < 4; c++) begin
          for (int r = 0; r < 4; r++) a[r] = m[r][c];
          for (int r = 0; r < 4; r++)
            m[r][c] = m_mul(a[r], 8'd14) ^ m_mul(a[(r+1)%4], 8'd11) ^
                      m_mul(a[(r+2)%4], 8'd13) ^ m_mul(a[(r+3)%4], 8'd9);
        end
    end
    res = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) res[127-8*(4*c+r) -: 8] = m[r][c];
    return res;
  endfunction

  function automatic bit model_hit(input bit dec, input logic [127:0] k);
    return dec && m_cache_valid && (k == m_cache_key);
  endfunction

  task automatic model_commit(input bit dec, input logic [127:0] k, input bit was_hit);
    if (!dec || !was_hit) begin
      m_cache_valid = 1'b1;
      m_cache_key   = k;
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- drivers ----------------
  task automatic pulse_reset();
    @(negedge CLK);
    nRST = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    m_cache_valid = 1'b0;
  endtask

  // One full transaction: accept, count edges until OUT_VALID, then take it.
  task automatic run_op(input bit dec, input logic [127:0] k, input logic [127:0] t,
                        output logic [127:0] res, output logic hit, output int lat);
    int guard;
    guard = 0;
    @(negedge CLK);
    while (!IN_READY && guard < 100) begin
      @(negedge CLK);
      guard++;
    end
    IN_VALID = 1'b1;
    ENCDEC   = dec;
    KEY      = k;
    TEXTIN   = t;
    @(posedge CLK);
    #1;
    IN_VALID = 1'b0;
    ENCDEC   = ~dec;
    KEY      = rand128();
    TEXTIN   = rand128();
    lat = 0;
    while (!OUT_VALID && lat < 100) begin
      @(posedge CLK);
      #1;
      lat++;
    end
    res = TEXTOUT;
    hit = CACHE_HIT;
    OUT_READY = 1'b1;
    @(posedge CLK);
    #1;
    OUT_READY = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    nRST = 1'b0;
    IN_VALID = 1'b0;
    OUT_READY = 1'b0;
    ENCDEC = 1'b0;
    KEY = '0;
    TEXTIN = '0;
    #22;
    checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("[TB] FAIL rst_out_valid got %b exp 0", OUT_VALID); end
    checks++; if (TEXTOUT !== '0) begin errors++; $display("[TB] FAIL rst_textout got %h exp 0", TEXTOUT); end
    checks++; if (CACHE_HIT !== 1'b0) begin errors++; $display("[TB] FAIL rst_cache_hit got %b exp 0", CACHE_HIT); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy got %b exp 0", BUSY); end
    checks++; if (IN_READY !== 1'b1) begin errors++; $display("[TB] FAIL rst_in_ready got %b exp 1", IN_READY); end
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_known_vectors();
    logic [127:0] k1, p1, c1, k2, c2, p2, res;
    logic hit;
    int lat;
    k1 = 128'h000102030405060708090a0b0c0d0e0f;
    p1 = 128'h00112233445566778899aabbccddeeff;
    c1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    k2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    c2 = 128'h3925841d02dc09fbdc118597196a0b32;
    p2 = 128'h3243f6a8885a308d313198a2e0370734;
    checks++; if (mdl_cipher(1'b0, k1, p1) !== c1) begin errors++; $display("[TB] FAIL model_enc got %h exp %h", mdl_cipher(1'b0, k1, p1), c1); end
    checks++; if (mdl_cipher(1'b1, k2, c2) !== p2) begin errors++; $display("[TB] FAIL model_dec got %h exp %h", mdl_cipher(1'b1, k2, c2), p2); end

    run_op(1'b0, k1, p1, res, hit, lat);
    model_commit(1'b0, k1, 1'b0);
    checks++; if (res !== c1) begin errors++; $display("[TB] FAIL t1_text got %h exp %h", res, c1); end
    checks++; if (lat != NCYC) begin errors++; $display("[TB] FAIL t1_latency got %0d exp %0d", lat, NCYC); end
    checks++; if (hit !== 1'b0) begin errors++; $display("[TB] FAIL t1_hit got %b exp 0", hit); end

    run_op(1'b1, k1, c1, res, hit, lat);
    checks++; if (res !== p1) begin errors++; $display("[TB] FAIL t2_text got %h exp %h", res, p1); end
    checks++; if (lat != NCYC) begin errors++; $display("[TB] FAIL t2_latency got %0d exp %0d", lat, NCYC); end
    checks++; if (hit !== 1'b1) begin errors++; $display("[TB] FAIL t2_hit got %b exp 1", hit); end
    checks++; if (TEXTOUT !== p1) begin errors++; $display("[TB] FAIL t2_retain got %h exp %h", TEXTOUT, p1); end

    pulse_reset();
    run_op(1'b1, k2, c2, res, hit, lat);
    model_commit(1'b1, k2, 1'b0);
    checks++; if (res !== p2) begin errors++; $display("[TB] FAIL t3_miss_text got %h exp %h", res, p2); end
    checks++; if (lat != 2 * NCYC) begin errors++; $display("[TB] FAIL t3_miss_latency got %0d exp %0d", lat, 2 * NCYC); end
    checks++; if (hit !== 1'b0) begin errors++; $display("[TB] FAIL t3_miss_hit got %b exp 0", hit); end
    run_op(1'b1, k2, c2, res, hit, lat);
    checks++; if (res !== p2) begin errors++; $display("[TB] FAIL t3_hit_text got %h exp %h", res, p2); end
    checks++; if (lat != NCYC) begin errors++; $display("[TB] FAIL t3_hit_latency got %0d exp %0d", lat, NCYC); end
    checks++; if (hit !== 1'b1) begin errors++; $display("[TB] FAIL t3_hit_hit got %b exp 1", hit); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] ka, ta, kb, tb, first, exp_b;
    int lat;
    ka = rand128(); ta = rand128();
    kb = rand128(); tb = rand128();
    exp_b = mdl_cipher(1'b0, kb, tb);
    @(negedge CLK);
    IN_VALID = 1'b1; ENCDEC = 1'b0; KEY = ka; TEXTIN = ta;
    @(posedge CLK);
    #1;
    IN_VALID = 1'b0;
    model_commit(1'b0, ka, 1'b0);
    lat = 0;
    while (!OUT_VALID && lat < 100) begin
      @(posedge CLK);
      #1;
      lat++;
    end
    first = TEXTOUT;
    checks++; if (first !== mdl_cipher(1'b0, ka, ta)) begin errors++; $display("[TB] FAIL bp_text got %h exp %h", first, mdl_cipher(1'b0, ka, ta)); end
    for (int i = 0; i < 7; i++) begin
      @(posedge CLK);
      #1;
      checks++;
      if (OUT_VALID !== 1'b1 || TEXTOUT !== first || IN_READY !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_hold cycle %0d got valid=%b ready=%b text=%h exp valid=1 ready=0 text=%h",
                 i, OUT_VALID, IN_READY, TEXTOUT, first);
      end
    end
    @(negedge CLK);
    OUT_READY = 1'b1;
    IN_VALID = 1'b1; ENCDEC = 1'b0; KEY = kb; TEXTIN = tb;
    #1;
    checks++; if (IN_READY !== 1'b1) begin errors++; $display("[TB] FAIL b2b_in_ready got %b exp 1", IN_READY); end
    @(posedge CLK);
    #1;
    OUT_READY = 1'b0;
    IN_VALID = 1'b0;
    KEY = rand128();
    model_commit(1'b0, kb, 1'b0);
    checks++; if (OUT_VALID !== 1'b0 || BUSY !== 1'b1) begin errors++; $display("[TB] FAIL b2b_accept got valid=%b busy=%b exp valid=0 busy=1", OUT_VALID, BUSY); end
    checks++; if (TEXTOUT !== first) begin errors++; $display("[TB] FAIL b2b_retain got %h exp %h", TEXTOUT, first); end
    lat = 0;
    while (!OUT_VALID && lat < 100) begin
      @(posedge CLK);
      #1;
      lat++;
    end
    checks++; if (lat != NCYC) begin errors++; $display("[TB] FAIL b2b_latency got %0d exp %0d", lat, NCYC); end
    checks++; if (TEXTOUT !== exp_b) begin errors++; $display("[TB] FAIL b2b_text got %h exp %h", TEXTOUT, exp_b); end
    OUT_READY = 1'b1;
    @(posedge CLK);
    #1;
    OUT_READY = 1'b0;
  endtask

  task automatic test_mid_reset();
    logic [127:0] k, p, c, res;
    logic hit;
    int lat;
    k = rand128();
    p = rand128();
    c = mdl_cipher(1'b0, k, p);
    run_op(1'b0, k, p, res, hit, lat);
    model_commit(1'b0, k, 1'b0);
    checks++; if (res !== c) begin errors++; $display("[TB] FAIL mr_enc_text got %h exp %h", res, c); end
    @(negedge CLK);
    IN_VALID = 1'b1; ENCDEC = 1'b1; KEY = k; TEXTIN = c;
    @(posedge CLK);
    #1;
    IN_VALID = 1'b0;
    repeat ((NCYC - 1) / 2) @(posedge CLK);
    #2;
    checks++; if (BUSY !== 1'b1 || OUT_VALID !== 1'b0) begin errors++; $display("[TB] FAIL mr_inflight got busy=%b valid=%b exp busy=1 valid=0", BUSY, OUT_VALID); end
    nRST = 1'b0;
    #1;
    checks++;
    if (OUT_VALID !== 1'b0 || TEXTOUT !== '0 || CACHE_HIT !== 1'b0 || BUSY !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mr_clear got valid=%b text=%h hit=%b busy=%b exp all 0", OUT_VALID, TEXTOUT, CACHE_HIT, BUSY);
    end
    @(negedge CLK);
    nRST = 1'b1;
    m_cache_valid = 1'b0;
    run_op(1'b1, k, c, res, hit, lat);
    model_commit(1'b1, k, 1'b0);
    checks++; if (res !== p) begin errors++; $display("[TB] FAIL mr_dec_text got %h exp %h", res, p); end
    checks++; if (hit !== 1'b0) begin errors++; $display("[TB] FAIL mr_dec_hit got %b exp 0", hit); end
    checks++; if (lat != 2 * NCYC) begin errors++; $display("[TB] FAIL mr_dec_latency got %0d exp %0d", lat, 2 * NCYC); end
  endtask

  task automatic test_random(input int n);
    logic [127:0] pool [3];
    logic [127:0] k, t, exp_text, res;
    logic hit;
    bit   dec, exp_hit;
    int   lat, exp_lat;
    for (int i = 0; i < 3; i++) pool[i] = rand128();
    for (int i = 0; i < n; i++) begin
      dec = ($urandom_range(0, 2) != 0);
      k = pool[$urandom_range(0, 2)];
      t = rand128();
      exp_hit = model_hit(dec, k);
      exp_text = mdl_cipher(dec, k, t);
      exp_lat = (dec && !exp_hit) ? 2 * NCYC : NCYC;
      run_op(dec, k, t, res, hit, lat);
      model_commit(dec, k, exp_hit);
      checks++; if (res !== exp_text) begin errors++; $display("[TB] FAIL rnd%0d_text dec=%0d got %h exp %h", i, dec, res, exp_text); end
      checks++; if (hit !== exp_hit) begin errors++; $display("[TB] FAIL rnd%0d_hit dec=%0d got %b exp %b", i, dec, hit, exp_hit); end
      checks++; if (lat != exp_lat) begin errors++; $display("[TB] FAIL rnd%0d_latency dec=%0d got %0d exp %0d", i, dec, lat, exp_lat); end
    end
  endtask

  initial begin
    build_tables();
    test_reset();
    test_known_vectors();
    test_back_to_back();
    test_mid_reset();
    test_random(24);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
